user_reg_arbiter: RTL and testbench
===================================

Name: user_reg_arbiter

Overview:
- Two-master arbiter and sequencer in front of the user register bank (16 × 16-bit registers; addr/wr_data/wr_valid/rw/rd_en in, rd_valid/rd_data out).
- Port A is the UART command decoder; port B is a fabric-side master.
- Serialises accesses, enforces the bank's edge-triggered read protocol and routes read data back to the correct requester.
- Sits between the UART command layer and the register bank.

Parameters:
- DATA_WIDTH, 16, register data width (matches bank data width).
- ADDR_WIDTH, 16, address bus width.
- NUM_REGS, 16, number of implemented registers; addresses >= NUM_REGS are out of range.
- RD_TIMEOUT, 15, maximum cycles to wait for bank read-valid before error.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- a_req  in  1  port A request; held with a_we/a_addr/a_wdata stable until a_done.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  port A register address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_done  out  1  one-cycle completion pulse.
- a_rdata  out  DATA_WIDTH  read data, valid with a_done.
- a_err  out  1  error flag, valid with a_done.
- b_req, b_we, b_addr, b_wdata, b_done, b_rdata, b_err: same as port A, for port B.
- bank_addr  out  ADDR_WIDTH  address to bank.
- bank_wr_data  out  DATA_WIDTH  write data to bank.
- bank_wr_valid  out  1  write strobe.
- bank_rw  out  1  0 = write, 1 = read.
- bank_rd_en  out  1  read enable; the bank detects its rising edge.
- bank_rd_valid  in  1  bank read-valid pulse.
- bank_rd_data  in  DATA_WIDTH  bank read data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high, named reset.
- Reset values: all outputs 0; FSM in IDLE; last_grant = B, so A wins the first tie. Reset mid-operation aborts the access with no done pulse; requesters must re-issue.
- All outputs are registered.
- FSM states: IDLE, WRITE, READ, WAIT_RD, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Only one req: grant it.
  - Both req: grant the port opposite last_grant (round-robin); update last_grant.
  - On grant, latch owner, we, addr and wdata into command registers.
  - addr >= NUM_REGS: go to DONE with err = 1, rdata = 0; the bank is not touched.
  - Otherwise go to WRITE (we = 1) or READ (we = 0).
- WRITE (1 cycle): bank_wr_valid = 1, bank_rw = 0, bank_addr/bank_wr_data = latched values → DONE.
- READ (1 cycle): bank_rd_en = 1, bank_rw = 1, bank_addr = latched addr → WAIT_RD; timeout counter cleared.
- WAIT_RD:
  - bank_rd_en = 0, bank_rw = 1.
  - On bank_rd_valid: capture bank_rd_data → DONE, err = 0.
  - Counter increments every cycle; on reaching RD_TIMEOUT without valid: → DONE, err = 1, rdata = 0.
- DONE (1 cycle): owner's done = 1 with rdata/err; the other port's done stays 0 → IDLE.
- bank_wr_valid and bank_rd_en are never high in the same cycle.
- bank_rd_en is high for exactly one cycle per read and low for at least 2 cycles between reads, which guarantees the bank sees a fresh rising edge.
- Latency from req first sampled in IDLE (edge E0):
  - Write: bank_wr_valid in cycle E0+1, done in E0+2.
  - Read with bank valid one cycle after rd_en: rd_en in E0+1, valid in E0+2, done in E0+3.
- Minimum spacing between accesses: one IDLE cycle after DONE.
- A req still high in the IDLE cycle after its done counts as a new request.
- rdata/err hold their last values between done pulses; a port's rdata is updated only on its own read completion.
- Changing we/addr/wdata while req is high and before done is unsupported; the latched values are used.
- bank_rd_valid arriving outside WAIT_RD is ignored.

Test Plan:
- Reset, then a_req write addr 0x0003 data 0xBEEF → bank_wr_valid one cycle with addr 3 / data 0xBEEF, bank_rw = 0; a_done two cycles after grant; a_err = 0.
- A reads 0x0003 (bank model returns 0xBEEF one cycle after rd_en rise) → bank_rd_en single-cycle pulse; a_done three cycles after grant with a_rdata = 0xBEEF, a_err = 0; b_done stays 0.
- a_req and b_req asserted in the same cycle, both held for four back-to-back reads → grants alternate A, B, A, B; each rd_en pulse separated by ≥ 2 low cycles; no write/read overlap.
- b_req write addr 0x0010 → no bank strobe; b_done with b_err = 1, b_rdata = 0.
- Bank model never asserts rd_valid → done arrives after RD_TIMEOUT (15) WAIT_RD cycles with err = 1, rdata = 0; next request serviced normally.
- Assert reset during WAIT_RD → all outputs 0 immediately (asynchronous); no done pulse; FSM in IDLE; subsequent A and B requests resolve with A winning first.

Source files
------------

// File: rtl/user_reg_arbiter.sv
// Two-master (A = UART decoder, B = fabric) arbiter/sequencer in front of the
// user register bank; serialises accesses and routes read data to the owner.
module user_reg_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_done,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_err,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_done,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_err,
  output logic [ADDR_WIDTH-1:0] bank_addr,
  output logic [DATA_WIDTH-1:0] bank_wr_data,
  output logic                  bank_wr_valid,
  output logic                  bank_rw,
  output logic                  bank_rd_en,
  input  logic                  bank_rd_valid,
  input  logic [DATA_WIDTH-1:0] bank_rd_data
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RD, DONE} state_t;

  state_t                state_q;
  logic                  owner_q;       // 1 = port B
  logic                  last_grant_q;  // 1 = port B
  logic [CNT_W-1:0]      cnt_q;
  logic                  a_done_q, b_done_q, a_err_q, b_err_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic [ADDR_WIDTH-1:0] bank_addr_q;
  logic [DATA_WIDTH-1:0] bank_wr_data_q;
  logic                  bank_wr_valid_q, bank_rw_q, bank_rd_en_q;

  logic                  any_req_s, grant_b_s, sel_we_s, sel_oor_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic                  fin_s, fin_owner_s, fin_err_s, fin_upd_s;
  logic [DATA_WIDTH-1:0] fin_rdata_s;

  assign any_req_s   = a_req | b_req;
  assign grant_b_s   = b_req & (~a_req | ~last_grant_q);
  assign sel_we_s    = grant_b_s ? b_we    : a_we;
  assign sel_addr_s  = grant_b_s ? b_addr  : a_addr;
  assign sel_wdata_s = grant_b_s ? b_wdata : a_wdata;
  assign sel_oor_s   = (sel_addr_s >= ADDR_WIDTH'(NUM_REGS));

  // Completion decode: when an access finishes this cycle, and with what result.
  always_comb begin
    fin_s       = 1'b0;
    fin_owner_s = owner_q;
    fin_err_s   = 1'b0;
    fin_upd_s   = 1'b0;
    fin_rdata_s = '0;
    case (state_q)
      IDLE: begin
        if (any_req_s && sel_oor_s) begin
          fin_s       = 1'b1;
          fin_owner_s = grant_b_s;
          fin_err_s   = 1'b1;
          fin_upd_s   = 1'b1;
        end else begin
          fin_s = 1'b0;
        end
      end
      WRITE: fin_s = 1'b1;
      WAIT_RD: begin
        if (bank_rd_valid) begin
          fin_s       = 1'b1;
          fin_upd_s   = 1'b1;
          fin_rdata_s = bank_rd_data;
        end else if (cnt_q == CNT_LAST) begin
          fin_s     = 1'b1;
          fin_err_s = 1'b1;
          fin_upd_s = 1'b1;
        end else begin
          fin_s = 1'b0;
        end
      end
      default: fin_s = 1'b0;
    endcase
  end

  // Sequencer FSM; bank strobes and done pulses are set on the transition into their state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      cnt_q           <= '0;
      a_done_q        <= 1'b0;
      b_done_q        <= 1'b0;
      a_err_q         <= 1'b0;
      b_err_q         <= 1'b0;
      a_rdata_q       <= '0;
      b_rdata_q       <= '0;
      bank_addr_q     <= '0;
      bank_wr_data_q  <= '0;
      bank_wr_valid_q <= 1'b0;
      bank_rw_q       <= 1'b0;
      bank_rd_en_q    <= 1'b0;
    end else begin
      a_done_q        <= 1'b0;
      b_done_q        <= 1'b0;
      bank_wr_valid_q <= 1'b0;
      bank_rd_en_q    <= 1'b0;
      if (fin_s) begin
        if (fin_owner_s) begin
          b_done_q <= 1'b1;
          b_err_q  <= fin_err_s;
          if (fin_upd_s) b_rdata_q <= fin_rdata_s;
        end else begin
          a_done_q <= 1'b1;
          a_err_q  <= fin_err_s;
          if (fin_upd_s) a_rdata_q <= fin_rdata_s;
        end
      end
      case (state_q)
        IDLE: begin
          if (any_req_s) begin
            owner_q      <= grant_b_s;
            last_grant_q <= grant_b_s;
            if (sel_oor_s) begin
              state_q <= DONE;
            end else if (sel_we_s) begin
              state_q         <= WRITE;
              bank_wr_valid_q <= 1'b1;
              bank_rw_q       <= 1'b0;
              bank_addr_q     <= sel_addr_s;
              bank_wr_data_q  <= sel_wdata_s;
            end else begin
              state_q      <= READ;
              bank_rd_en_q <= 1'b1;
              bank_rw_q    <= 1'b1;
              bank_addr_q  <= sel_addr_s;
            end
          end
        end
        WRITE: state_q <= DONE;
        READ: begin
          state_q <= WAIT_RD;
          cnt_q   <= '0;
        end
        WAIT_RD: begin
          if (fin_s) begin
            state_q   <= DONE;
            bank_rw_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_done        = a_done_q;
  assign a_rdata       = a_rdata_q;
  assign a_err         = a_err_q;
  assign b_done        = b_done_q;
  assign b_rdata       = b_rdata_q;
  assign b_err         = b_err_q;
  assign bank_addr     = bank_addr_q;
  assign bank_wr_data  = bank_wr_data_q;
  assign bank_wr_valid = bank_wr_valid_q;
  assign bank_rw       = bank_rw_q;
  assign bank_rd_en    = bank_rd_en_q;

endmodule

// File: tb/tb_user_reg_arbiter.sv
// Directed bench for user_reg_arbiter with a behavioural register-bank model
// that answers a rising rd_en one cycle later.
module tb_user_reg_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] a_addr = 16'h0, a_wdata = 16'h0, b_addr = 16'h0, b_wdata = 16'h0;
  logic        a_done, a_err, b_done, b_err;
  logic [15:0] a_rdata, b_rdata;
  logic [15:0] bank_addr, bank_wr_data;
  logic        bank_wr_valid, bank_rw, bank_rd_en;
  logic        bank_rd_valid = 1'b0;
  logic [15:0] bank_rd_data = 16'h0;

  int checks = 0;
  int failures = 0;

  user_reg_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
    .bank_addr(bank_addr), .bank_wr_data(bank_wr_data), .bank_wr_valid(bank_wr_valid),
    .bank_rw(bank_rw), .bank_rd_en(bank_rd_en),
    .bank_rd_valid(bank_rd_valid), .bank_rd_data(bank_rd_data)
  );

  always #5 clk = ~clk;

  // Bank model: 16 registers, read answered one cycle after a rising rd_en.
  logic [15:0] mem [16];
  logic        rd_en_prev = 1'b0;
  logic        respond = 1'b1;
  initial for (int i = 0; i < 16; i++) mem[i] = 16'h0;
  always @(posedge clk) begin
    rd_en_prev    <= bank_rd_en;
    bank_rd_valid <= 1'b0;
    if (bank_rd_en && !rd_en_prev && respond) begin
      bank_rd_valid <= 1'b1;
      bank_rd_data  <= mem[bank_addr[3:0]];
    end
    if (bank_wr_valid) mem[bank_addr[3:0]] <= bank_wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Protocol monitor: no strobe overlap, single-cycle rd_en, >= 2 low cycles between reads.
  int   low_cnt = 100;
  logic mon_prev = 1'b0;
  always @(negedge clk) begin
    if (bank_wr_valid || bank_rd_en) chk("strobe_overlap", {31'd0, bank_wr_valid & bank_rd_en}, 32'd0);
    if (bank_rd_en) begin
      if (mon_prev) chk("rd_en_width", 32'd2, 32'd1);
      else chk("rd_en_gap_ok", {31'd0, low_cnt >= 2}, 32'd1);
      low_cnt = 0;
    end else begin
      low_cnt++;
    end
    mon_prev = bank_rd_en;
  end

  task automatic set_port(input logic port, input logic req, input logic we,
                          input logic [15:0] addr, input logic [15:0] wdata);
    if (port) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
    end
  endtask

  // One access from an idle arbiter; latency counted in negedges after the grant edge.
  task automatic do_access(input string name, input logic port, input logic we,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic exp_err, input logic [15:0] exp_rdata,
                           input int exp_lat, input int exp_wr, input int exp_rd);
    int   cyc, wr_at, rd_at, wr_n, rd_n;
    logic got, other;
    logic [15:0] rdata;
    logic err;
    cyc = 0; wr_at = 0; rd_at = 0; wr_n = 0; rd_n = 0; got = 1'b0; other = 1'b0;
    rdata = 16'h0; err = 1'b0;
    @(negedge clk);
    set_port(port, 1'b1, we, addr, wdata);
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bank_wr_valid) begin
        wr_n++; wr_at = cyc;
        chk({name, "_wr_addr"}, {16'd0, bank_addr}, {16'd0, addr});
        chk({name, "_wr_data"}, {16'd0, bank_wr_data}, {16'd0, wdata});
        chk({name, "_wr_rw"}, {31'd0, bank_rw}, 32'd0);
      end
      if (bank_rd_en) begin
        rd_n++; rd_at = cyc;
        chk({name, "_rd_addr"}, {16'd0, bank_addr}, {16'd0, addr});
        chk({name, "_rd_rw"}, {31'd0, bank_rw}, 32'd1);
      end
      if (port ? a_done : b_done) other = 1'b1;
      if (port ? b_done : a_done) begin
        got = 1'b1;
        rdata = port ? b_rdata : a_rdata;
        err = port ? b_err : a_err;
      end
    end
    set_port(port, 1'b0, 1'b0, 16'h0, 16'h0);
    chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({name, "_latency"}, cyc, exp_lat);
    chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    chk({name, "_rdata"}, {16'd0, rdata}, {16'd0, exp_rdata});
    chk({name, "_other_done"}, {31'd0, other}, 32'd0);
    chk({name, "_wr_at"}, wr_at, exp_wr);
    chk({name, "_wr_count"}, wr_n, (exp_wr != 0) ? 1 : 0);
    chk({name, "_rd_at"}, rd_at, exp_rd);
    chk({name, "_rd_count"}, rd_n, (exp_rd != 0) ? 1 : 0);
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        err;
    logic [15:0] rdata;
    int          lat;
    int          wr_at;
    int          rd_at;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int   ndone, cyc;
    logic seen, first_a;
    vecs[0] = '{1'b0, 1'b1, 16'h0003, 16'hBEEF, 1'b0, 16'h0000, 2, 1, 0};
    vecs[1] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'hBEEF, 3, 0, 1};
    vecs[2] = '{1'b1, 1'b1, 16'h0010, 16'hA5A5, 1'b1, 16'h0000, 1, 0, 0};
    vecs[3] = '{1'b1, 1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0000, 2, 1, 0};
    vecs[4] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h1234, 3, 0, 1};
    vecs[5] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'hBEEF, 3, 0, 1};
    vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1, 0, 0};
    vecs[7] = '{1'b1, 1'b1, 16'h000F, 16'h0F0F, 1'b0, 16'hBEEF, 2, 1, 0};
    vecs[8] = '{1'b1, 1'b0, 16'h000F, 16'h0000, 1'b0, 16'h0F0F, 3, 0, 1};

    repeat (3) @(negedge clk);
    chk("reset_a", {a_done, a_err, a_rdata}, 32'd0);
    chk("reset_b", {b_done, b_err, b_rdata}, 32'd0);
    chk("reset_bank", {bank_wr_valid, bank_rw, bank_rd_en, bank_addr}, 32'd0);
    chk("reset_wdata", {16'd0, bank_wr_data}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      do_access($sformatf("v%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                vecs[i].err, vecs[i].rdata, vecs[i].lat, vecs[i].wr_at, vecs[i].rd_at);

    // Both ports held for four reads: last grant was B, so order is A, B, A, B.
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0);
    set_port(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0);
    ndone = 0; cyc = 0;
    while (ndone < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (a_done || b_done) begin
        chk($sformatf("rr%0d_owner", ndone), {30'd0, a_done, b_done},
            (ndone % 2 == 0) ? 32'd2 : 32'd1);
        if (a_done) chk($sformatf("rr%0d_a_rdata", ndone), {16'd0, a_rdata}, 32'h0000BEEF);
        if (b_done) chk($sformatf("rr%0d_b_rdata", ndone), {16'd0, b_rdata}, 32'h00001234);
        ndone++;
      end
    end
    set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    chk("rr_count", ndone, 4);

    // Bank silent: 15 WAIT_RD cycles then error; then a normal read.
    respond = 1'b0;
    do_access("tmo", 1'b0, 1'b0, 16'h0003, 16'h0, 1'b1, 16'h0000, 17, 0, 1);
    respond = 1'b1;
    do_access("post_tmo", 1'b0, 1'b0, 16'h0005, 16'h0, 1'b0, 16'h1234, 3, 0, 1);

    // Asynchronous reset while waiting for read data.
    respond = 1'b0;
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | a_done | b_done;
    end
    chk("wait_rd_rw", {31'd0, bank_rw}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_reset_a", {a_done, a_err, a_rdata}, 32'd0);
    chk("mid_reset_b", {b_done, b_err, b_rdata}, 32'd0);
    chk("mid_reset_bank", {bank_wr_valid, bank_rw, bank_rd_en, bank_addr}, 32'd0);
    @(negedge clk);
    respond = 1'b1;
    set_port(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0);
    @(negedge clk);
    seen = seen | a_done | b_done;
    chk("no_done_before_reset_release", {31'd0, seen}, 32'd0);
    reset = 1'b0;
    ndone = 0; cyc = 0; first_a = 1'b0;
    while (ndone < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (a_done || b_done) begin
        if (ndone == 0) first_a = a_done;
        if (a_done) begin
          chk("post_reset_a_rdata", {16'd0, a_rdata}, 32'h0000BEEF);
          set_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        if (b_done) begin
          chk("post_reset_b_rdata", {16'd0, b_rdata}, 32'h00001234);
          set_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        ndone++;
      end
    end
    chk("post_reset_a_first", {31'd0, first_a}, 32'd1);
    chk("post_reset_count", ndone, 2);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
